// File: rtl/mem_burst_host.sv
// mem_burst_host: command-driven burst host with write/read data FIFOs.
// Optional handshake watchdog is built when MEM_BURST_HOST_TIMEOUT_EN is defined.
module mem_burst_host #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_stb_i,
    input  logic        cmd_we_i,
    input  logic [15:0] cmd_len_i,
    input  logic [31:0] cmd_addr_i,
    output logic        cmd_busy_o,
    output logic        cmd_done_o,
    output logic        err_o,
    input  logic        wr_push_i,
    input  logic [15:0] wr_dat_i,
    output logic        wr_full_o,
    input  logic        rd_pop_i,
    output logic [15:0] rd_dat_o,
    output logic        rd_empty_o,
    output logic        bus_stb_o,
    output logic        bus_seq_o,
    output logic        bus_we_o,
    output logic [15:0] bus_len_o,
    output logic [31:0] bus_addr_o,
    output logic [15:0] bus_dat_o,
    output logic        bus_rst_o,
    input  logic        bus_cyc_i,
    input  logic        bus_seq_i,
    input  logic [15:0] bus_dat_i
);
    localparam int AW = $clog2(FIFO_DEPTH);

    // state | meaning
    // IDLE  | waiting for a command
    // START | bus_stb_o raised, waiting for bus_cyc_i
    // WORD  | waiting for write data or read FIFO space
    // SEQ   | bus_seq_o raised, waiting for bus_seq_i
    // REL   | waiting for bus_seq_i to drop
    // DONE  | waiting for bus_cyc_i to drop
    typedef enum logic [2:0] {S_IDLE, S_START, S_WORD, S_SEQ, S_REL, S_DONE} state_t;

    state_t        r_state;
    logic [14:0]   r_rem;
    logic          r_stb, r_seq, r_we, r_busy, r_done;
    logic [15:0]   r_len, r_dat;
    logic [31:0]   r_addr;

    logic [15:0]   r_wmem [FIFO_DEPTH];
    logic [AW-1:0] r_wwp, r_wrp;
    logic [AW:0]   r_wcnt;
    logic [15:0]   r_rmem [FIFO_DEPTH];
    logic [AW-1:0] r_rwp, r_rrp;
    logic [AW:0]   r_rcnt;

    logic w_wpush, w_wpop, w_wempty, w_rpush, w_rpop, w_rfull;
    logic w_cmd_acc, w_tmo_hit;

    assign w_cmd_acc = (r_state == S_IDLE) && cmd_stb_i && (cmd_len_i[15:1] != 15'd0);
    assign w_wempty  = (r_wcnt == '0);
    assign wr_full_o = (r_wcnt == (AW+1)'(FIFO_DEPTH));
    assign w_rfull   = (r_rcnt == (AW+1)'(FIFO_DEPTH));
    assign rd_empty_o = (r_rcnt == '0);
    assign w_wpush   = wr_push_i && !wr_full_o;
    assign w_wpop    = (r_state == S_WORD) && !r_we && !w_wempty;
    assign w_rpush   = (r_state == S_SEQ) && r_we && bus_seq_i && !w_tmo_hit;
    assign w_rpop    = rd_pop_i && !rd_empty_o;
    assign rd_dat_o  = r_rmem[r_rrp];

    always_ff @(posedge clk_i) begin
        if (w_wpush) r_wmem[r_wwp] <= wr_dat_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wwp  <= '0;
            r_wrp  <= '0;
            r_wcnt <= '0;
        end else begin
            if (w_wpush) r_wwp <= r_wwp + 1'b1;
            if (w_wpop)  r_wrp <= r_wrp + 1'b1;
            r_wcnt <= r_wcnt + {{AW{1'b0}}, w_wpush} - {{AW{1'b0}}, w_wpop};
        end
    end

    // read storage is cleared on reset so the show-ahead output starts at zero
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_rmem[i] <= '0;
            r_rwp  <= '0;
            r_rrp  <= '0;
            r_rcnt <= '0;
        end else begin
            if (w_rpush) begin
                r_rmem[r_rwp] <= bus_dat_i;
                r_rwp         <= r_rwp + 1'b1;
            end
            if (w_rpop) r_rrp <= r_rrp + 1'b1;
            r_rcnt <= r_rcnt + {{AW{1'b0}}, w_rpush} - {{AW{1'b0}}, w_rpop};
        end
    end

`ifdef MEM_BURST_HOST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    state_t        r_state_d;
    logic [TW-1:0] r_tmo_cnt;
    logic          r_tmo_pls, r_err;
    logic [TW-1:0] w_tmo_eff;
    logic          w_tmo_cnting;

    assign w_tmo_cnting = (r_state == S_START) || (r_state == S_SEQ) ||
                          (r_state == S_REL)   || (r_state == S_DONE);
    // count restarts in the first cycle of every new state
    assign w_tmo_eff = (r_state != r_state_d) ? '0 : r_tmo_cnt;
    assign w_tmo_hit = w_tmo_cnting && (w_tmo_eff == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state_d <= S_IDLE;
            r_tmo_cnt <= '0;
            r_tmo_pls <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state_d <= r_state;
            r_tmo_cnt <= w_tmo_cnting ? w_tmo_eff + 1'b1 : '0;
            r_tmo_pls <= w_tmo_hit;
            if (w_tmo_hit)      r_err <= 1'b1;
            else if (w_cmd_acc) r_err <= 1'b0;
        end
    end

    assign err_o     = r_err;
    assign bus_rst_o = rst_i | r_tmo_pls;
`else
    assign w_tmo_hit = 1'b0;
    assign err_o     = 1'b0;
    assign bus_rst_o = rst_i;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_stb   <= 1'b0;
            r_seq   <= 1'b0;
            r_we    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_len   <= '0;
            r_addr  <= '0;
            r_dat   <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_tmo_hit) begin
                r_state <= S_IDLE;
                r_stb   <= 1'b0;
                r_seq   <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: if (cmd_stb_i) begin
                        if (w_cmd_acc) begin
                            r_len   <= cmd_len_i;
                            r_addr  <= cmd_addr_i;
                            r_we    <= cmd_we_i;
                            r_rem   <= cmd_len_i[15:1];
                            r_stb   <= 1'b1;
                            r_busy  <= 1'b1;
                            r_state <= S_START;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                    S_START: if (bus_cyc_i) begin
                        r_stb   <= 1'b0;
                        r_state <= S_WORD;
                    end
                    S_WORD: if (r_we) begin
                        if (!w_rfull) begin
                            r_seq   <= 1'b1;
                            r_state <= S_SEQ;
                        end
                    end else if (!w_wempty) begin
                        r_dat   <= r_wmem[r_wrp];
                        r_seq   <= 1'b1;
                        r_state <= S_SEQ;
                    end
                    S_SEQ: if (bus_seq_i) begin
                        r_seq   <= 1'b0;
                        r_rem   <= r_rem - 15'd1;
                        r_state <= S_REL;
                    end
                    S_REL: if (!bus_seq_i) begin
                        r_state <= (r_rem == 15'd0) ? S_DONE : S_WORD;
                    end
                    S_DONE: if (!bus_cyc_i) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus_stb_o  = r_stb;
    assign bus_seq_o  = r_seq;
    assign bus_we_o   = r_we;
    assign bus_len_o  = r_len;
    assign bus_addr_o = r_addr;
    assign bus_dat_o  = r_dat;
    assign cmd_busy_o = r_busy;
    assign cmd_done_o = r_done;
endmodule

// File: tb/tb_mem_burst_host.sv
// Bench for mem_burst_host: random burst-engine responder, queue-based reference
// model and a negedge monitor that scores every handshake, pop and completion.
module tb_mem_burst_host;
    localparam int DEPTH = 8;
`ifdef MEM_BURST_HOST_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_stb_i, cmd_we_i;
    logic [15:0] cmd_len_i;
    logic [31:0] cmd_addr_i;
    logic        cmd_busy_o, cmd_done_o, err_o;
    logic        wr_push_i;
    logic [15:0] wr_dat_i;
    logic        wr_full_o;
    logic        rd_pop_i;
    logic [15:0] rd_dat_o;
    logic        rd_empty_o;
    logic        bus_stb_o, bus_seq_o, bus_we_o, bus_rst_o;
    logic [15:0] bus_len_o, bus_dat_o;
    logic [31:0] bus_addr_o;
    logic        bus_cyc_i, bus_seq_i;
    logic [15:0] bus_dat_i;

    mem_burst_host #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_stb_i(cmd_stb_i), .cmd_we_i(cmd_we_i), .cmd_len_i(cmd_len_i), .cmd_addr_i(cmd_addr_i),
        .cmd_busy_o(cmd_busy_o), .cmd_done_o(cmd_done_o), .err_o(err_o),
        .wr_push_i(wr_push_i), .wr_dat_i(wr_dat_i), .wr_full_o(wr_full_o),
        .rd_pop_i(rd_pop_i), .rd_dat_o(rd_dat_o), .rd_empty_o(rd_empty_o),
        .bus_stb_o(bus_stb_o), .bus_seq_o(bus_seq_o), .bus_we_o(bus_we_o), .bus_len_o(bus_len_o),
        .bus_addr_o(bus_addr_o), .bus_dat_o(bus_dat_o), .bus_rst_o(bus_rst_o),
        .bus_cyc_i(bus_cyc_i), .bus_seq_i(bus_seq_i), .bus_dat_i(bus_dat_i)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_wr[$];
    logic [15:0] exp_rd[$];
    int          exp_done[$];
    int          hs_cnt = 0;
    int          stb_cyc_run = 0;
    int          cyc_no = 0;
    bit          eng_hang = 1'b0;
    bit          eng_active = 1'b0;
    int          eng_words = 0;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc_no++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bad(input string name, input string what);
        n_tests++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endtask

    // monitor: scores DUT activity against the reference queues
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (rd_pop_i && !rd_empty_o) begin
                if (exp_rd.size() == 0) bad("rd_pop", "read data present but model empty");
                else chk("rd_dat", rd_dat_o, exp_rd.pop_front());
            end
            if (bus_seq_o && bus_seq_i) begin
                hs_cnt++;
                if (bus_we_o) exp_rd.push_back(bus_dat_i);
                else if (exp_wr.size() == 0) bad("wr_hs", "write handshake with model FIFO empty");
                else chk("bus_dat", bus_dat_o, exp_wr.pop_front());
            end
            if (cmd_done_o) begin
                if (exp_done.size() == 0) bad("cmd_done", "unexpected completion pulse");
                else begin
                    chk("done_words", hs_cnt, exp_done.pop_front());
                    hs_cnt = 0;
                end
            end
            if (bus_stb_o && bus_cyc_i) begin
                stb_cyc_run++;
                chk("stb_with_cyc_run", (stb_cyc_run > 1), 0);
            end else begin
                stb_cyc_run = 0;
            end
        end
    end

    // burst engine responder
    initial begin
        bus_cyc_i = 1'b0;
        bus_seq_i = 1'b0;
        bus_dat_i = '0;
        forever begin
            @(posedge clk_i); #1;
            if (bus_rst_o) begin
                bus_cyc_i = 1'b0;
                bus_seq_i = 1'b0;
                eng_active = 1'b0;
            end else if (!eng_active) begin
                if (bus_stb_o) begin
                    bus_cyc_i = 1'b1;
                    eng_words = int'(bus_len_o >> 1);
                    eng_active = 1'b1;
                end
            end else if (bus_seq_i) begin
                if (!bus_seq_o) begin
                    bus_seq_i = 1'b0;
                    eng_words--;
                    if (eng_words == 0) begin
                        bus_cyc_i = 1'b0;
                        eng_active = 1'b0;
                    end
                end
            end else if (bus_seq_o && !eng_hang && $urandom_range(0, 2) != 0) begin
                bus_seq_i = 1'b1;
                bus_dat_i = 16'($urandom);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i); #1;
    endtask

    task automatic push_wr(input logic [15:0] d);
        wr_push_i = 1'b1;
        wr_dat_i  = d;
        if (exp_wr.size() < DEPTH) exp_wr.push_back(d);
        tick();
        wr_push_i = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [15:0] len, input logic [31:0] addr);
        cmd_we_i   = we;
        cmd_len_i  = len;
        cmd_addr_i = addr;
        cmd_stb_i  = 1'b1;
        exp_done.push_back(int'(len >> 1));
        tick();
        cmd_stb_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, input bit rand_pop);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            rd_pop_i = rand_pop ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            if (!cmd_busy_o && exp_done.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        rd_pop_i = 1'b0;
        if (!ok) bad(name, "command did not complete within cycle budget");
    endtask

    task automatic drain_rd(input string name);
        for (int i = 0; i < 40 && exp_rd.size() > 0; i++) begin
            rd_pop_i = 1'b1;
            tick();
        end
        rd_pop_i = 1'b0;
        chk({name, "_model_empty"}, exp_rd.size(), 0);
        chk({name, "_rd_empty"}, rd_empty_o, 1);
    endtask

    task automatic check_reset(input string p);
        chk({p, "_stb"}, bus_stb_o, 0);
        chk({p, "_seq"}, bus_seq_o, 0);
        chk({p, "_we"}, bus_we_o, 1);
        chk({p, "_len"}, bus_len_o, 0);
        chk({p, "_addr"}, bus_addr_o, 0);
        chk({p, "_dat"}, bus_dat_o, 0);
        chk({p, "_busy"}, cmd_busy_o, 0);
        chk({p, "_done"}, cmd_done_o, 0);
        chk({p, "_err"}, err_o, 0);
        chk({p, "_rd_dat"}, rd_dat_o, 0);
        chk({p, "_rd_empty"}, rd_empty_o, 1);
        chk({p, "_wr_full"}, wr_full_o, 0);
        chk({p, "_bus_rst"}, bus_rst_o, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int t0, t1;
        bit ok;
        rst_i = 1'b1;
        cmd_stb_i = 1'b0; cmd_we_i = 1'b0; cmd_len_i = '0; cmd_addr_i = '0;
        wr_push_i = 1'b0; wr_dat_i = '0; rd_pop_i = 1'b0;
        repeat (3) tick();
        check_reset("rst");
        rst_i = 1'b0;
        tick();

        // three-word write
        push_wr(16'h1111); push_wr(16'h2222); push_wr(16'h3333);
        issue(1'b0, 16'd6, 32'h100);
        wait_done("wr3", 200, 1'b0);
        chk("wr3_addr", bus_addr_o, 32'h100);
        chk("wr3_len", bus_len_o, 16'd6);
        chk("wr3_we", bus_we_o, 0);
        chk("wr3_dat_hold", bus_dat_o, 16'h3333);

        // write FIFO must be empty now: a one-word write stalls until data arrives
        issue(1'b0, 16'd2, 32'h200);
        repeat (20) tick();
        chk("wr_empty_stall_hs", hs_cnt, 0);
        chk("wr_empty_stall_busy", cmd_busy_o, 1);
        push_wr(16'hBEEF);
        wait_done("wr_late", 200, 1'b0);

        // two-word read, popped afterwards
        issue(1'b1, 16'd4, 32'h300);
        wait_done("rd2", 200, 1'b0);
        chk("rd2_not_empty", rd_empty_o, (exp_rd.size() == 0));
        drain_rd("rd2");

        // read backpressure: ten words, no pops
        issue(1'b1, 16'd20, 32'h400);
        repeat (80) tick();
        chk("bp_stall_words", hs_cnt, DEPTH);
        chk("bp_stall_busy", cmd_busy_o, 1);
        chk("bp_stall_seq", bus_seq_o, 0);
        rd_pop_i = 1'b1;
        repeat (2) tick();
        rd_pop_i = 1'b0;
        wait_done("bp_finish", 200, 1'b0);
        drain_rd("bp");

        // zero- and one-byte commands
        for (int l = 0; l < 2; l++) begin
            issue(1'($urandom_range(0, 1)), 16'(l), 32'h500);
            chk("short_done", cmd_done_o, 1);
            chk("short_stb", bus_stb_o, 0);
            tick();
            chk("short_done_clr", cmd_done_o, 0);
            chk("short_busy", cmd_busy_o, 0);
        end

        // push past full: the extra word is dropped
        for (int i = 0; i <= DEPTH; i++) push_wr(16'($urandom));
        chk("wr_full", wr_full_o, (exp_wr.size() == DEPTH));
        issue(1'b0, 16'(2 * DEPTH), 32'h600);
        wait_done("wr_full_drain", 400, 1'b0);
        chk("wr_full_clr", wr_full_o, 0);

        // randomized commands
        for (int n = 0; n < 25; n++) begin
            logic we;
            int words;
            we = 1'($urandom_range(0, 1));
            words = we ? int'($urandom_range(0, 12)) : int'($urandom_range(0, DEPTH));
            if (!we) for (int i = 0; i < words; i++) push_wr(16'($urandom));
            issue(we, 16'(2 * words + int'($urandom_range(0, 1))), $urandom);
            wait_done("rand_cmd", 600, we);
            drain_rd("rand");
        end

        // reset in the middle of a four-word write
        for (int i = 0; i < 4; i++) push_wr(16'($urandom));
        issue(1'b0, 16'd8, 32'h700);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus_seq_o && hs_cnt >= 1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) bad("midrst_reach_seq", "second word never reached SEQ");
        #2 rst_i = 1'b1;
        #1 check_reset("midrst");
        exp_wr.delete(); exp_rd.delete(); exp_done.delete(); hs_cnt = 0;
        repeat (2) tick();
        rst_i = 1'b0;
        repeat (10) tick();
        chk("midrst_idle_busy", cmd_busy_o, 0);
        push_wr(16'hA5A5);
        issue(1'b0, 16'd2, 32'h800);
        wait_done("post_rst_wr", 200, 1'b0);
        chk("post_rst_dat", bus_dat_o, 16'hA5A5);

`ifdef MEM_BURST_HOST_TIMEOUT_EN
        eng_hang = 1'b1;
        push_wr(16'h7777);
        issue(1'b0, 16'd2, 32'h900);
        t0 = -1;
        t1 = -1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus_seq_o) begin
                t0 = cyc_no;
                break;
            end
        end
        for (int i = 0; i < 60 && t0 >= 0; i++) begin
            tick();
            if (bus_rst_o) begin
                t1 = cyc_no;
                break;
            end
        end
        if (t0 < 0 || t1 < 0) bad("tmo_pulse", "no bus_seq_o or bus_rst_o pulse seen");
        else chk("tmo_delay", t1 - t0, TMO);
        chk("tmo_err", err_o, 1);
        chk("tmo_busy", cmd_busy_o, 0);
        chk("tmo_seq", bus_seq_o, 0);
        tick();
        chk("tmo_pulse_width", bus_rst_o, 0);
        exp_done.delete(); exp_wr.delete(); hs_cnt = 0;
        eng_hang = 1'b0;
        issue(1'b1, 16'd2, 32'hA00);
        chk("tmo_err_clr", err_o, 0);
        wait_done("post_tmo_rd", 200, 1'b0);
        drain_rd("post_tmo");
`else
        t0 = 0;
        t1 = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
